// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue.
//   INSTR_W       : instruction width
//   fetch_entry_t : {pc, instr} queue payload (default XLEN of 32)
//   fetch_state_t : fetch control states
package fetch_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned XLEN_DEF = 32;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [INSTR_W-1:0]  instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO holding fetched {pc, instr} entries.
//   clk, rstn   : clock, async active-low reset
//   i_push      : write i_push_data at the tail
//   i_pop       : advance the head
//   i_clear     : drop all entries (wins over push/pop)
//   o_count     : occupied entries
//   o_head      : entry at the head (don't-care when empty)
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         entry_t = fetch_entry_t,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_push,
   input  entry_t        i_push_data,
   input  logic          i_pop,
   input  logic          i_clear,
   output logic [CW-1:0] o_count,
   output entry_t        o_head
);

   entry_t        r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [CW-1:0] r_count;

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (i_pop)  r_rd <= r_rd + AW'(1);
         if (i_push) r_wr <= r_wr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage needs no reset; only occupied slots are ever read
   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[r_wr] <= i_push_data;
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd];

   // Issue throttling must make a push into a full queue impossible
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      i_push |-> (r_count < CW'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential imem reads, absorbs the
// one-cycle memory latency and buffers fetched instructions for decode.
//   clk, rstn              : clock, async active-low reset
//   redirect_valid/_pc     : restart fetch at a new PC, flushing the queue
//   halt                   : stop issuing reads, keep queued entries
//   imem_ren/_raddr/_rdata : instruction memory port (data one cycle later)
//   out_valid/_ready       : decode handshake on the head entry
//   out_pc/_instr          : head entry
//   count                  : occupied queue entries
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0000_0000),
   localparam int unsigned     CW       = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   input  logic               halt,
   output logic               imem_ren,
   output logic [XLEN-1:0]    imem_raddr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [CW-1:0]      count
);

   localparam int unsigned OW = CW + 1;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc;
   logic            r_inflight;
   logic [XLEN-1:0] r_inflight_pc;

   logic            w_issue;
   logic            w_push;
   logic            w_pop;
   logic [OW-1:0]   w_occ;
   logic [CW-1:0]   w_count;
   entry_t          w_push_data;
   entry_t          w_head;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_BOOT;
      else       r_state <= w_state_nxt;
   end

   // Next state: BOOT lasts exactly one cycle after reset release
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BOOT:   w_state_nxt = ST_RUN;
         ST_RUN:    if (halt)  w_state_nxt = ST_HALTED;
         ST_HALTED: if (!halt) w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_BOOT;
      endcase
   end

   // Queued plus in-flight entries bound issue; a redirect flushes the
   // queue in the same cycle so it may always issue
   assign w_occ      = OW'(w_count) + OW'(r_inflight);
   assign w_issue    = (r_state == ST_RUN) && !halt &&
                       (redirect_valid || (w_occ < OW'(DEPTH)));
   assign imem_ren   = w_issue;
   assign imem_raddr = redirect_valid ? redirect_pc : r_fetch_pc;

   // Fetch PC and in-flight tracking
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         if (w_issue)             r_fetch_pc <= imem_raddr + XLEN'(4);
         else if (redirect_valid) r_fetch_pc <= redirect_pc;
         r_inflight <= w_issue;
         if (w_issue) r_inflight_pc <= imem_raddr;
      end
   end

   // Returning data from a read issued before a redirect is dropped
   always_comb begin
      w_push_data       = '0;
      w_push_data.pc    = r_inflight_pc;
      w_push_data.instr = imem_rdata;
   end
   assign w_push = r_inflight && !redirect_valid;
   assign w_pop  = out_valid && out_ready;

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .i_clear     (redirect_valid),
      .o_count     (w_count),
      .o_head      (w_head)
   );

   assign count     = w_count;
   assign out_valid = (w_count != '0);
   assign out_pc    = w_head.pc;
   assign out_instr = w_head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: randomized stimulus against a queue-based
// reference model, with a decoupled negedge monitor consuming expectations.
module tb_fetch_queue;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk;
   logic        rstn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        imem_ren;
   logic [31:0] imem_raddr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;

   fetch_queue #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .imem_ren       (imem_ren),
      .imem_raddr     (imem_raddr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .count          (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: data = address ^ KEY one cycle after the strobe, junk otherwise
   always @(posedge clk) begin
      if (imem_ren) imem_rdata <= imem_raddr ^ KEY;
      else          imem_rdata <= $urandom;
   end

   typedef struct {
      logic        ren;
      logic [31:0] raddr;
      int          cnt;
   } cyc_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   cyc_t cyc_q[$];   // per-cycle expectations for the fetch side
   ent_t out_q[$];   // entries decode is expected to accept, in order

   // Reference model: program-order fetch with a bounded buffer
   int          m_st;       // 0 boot, 1 run, 2 halted
   logic [31:0] m_fpc;
   ent_t        m_fifo[$];
   bit          m_infl;
   logic [31:0] m_infl_pc;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endfunction

   // One clock cycle of stimulus plus the model's view of that cycle
   task automatic cyc(input bit rdy, input bit hlt, input bit rv,
                      input logic [31:0] rpc, input bit rst);
      cyc_t        e;
      bit          iss;
      logic [31:0] ra;
      @(posedge clk);
      #1;
      out_ready      = rdy;
      halt           = hlt;
      redirect_valid = rst ? 1'b0 : rv;
      redirect_pc    = rpc;
      rstn           = !rst;
      if (rst) begin
         m_st   = 0;
         m_fpc  = RESET_PC;
         m_fifo.delete();
         m_infl = 1'b0;
         e = '{1'b0, RESET_PC, 0};
         cyc_q.push_back(e);
         return;
      end
      ra  = rv ? rpc : m_fpc;
      iss = (m_st == 1) && !hlt && (rv || (m_fifo.size() + int'(m_infl) < DEPTH));
      e = '{iss, ra, m_fifo.size()};
      cyc_q.push_back(e);
      if (m_fifo.size() != 0 && rdy) out_q.push_back(m_fifo.pop_front());
      if (rv)          m_fifo.delete();
      else if (m_infl) m_fifo.push_back('{m_infl_pc, m_infl_pc ^ KEY});
      if (iss)     m_fpc = ra + 32'd4;
      else if (rv) m_fpc = rpc;
      m_infl    = iss;
      m_infl_pc = ra;
      case (m_st)
         0:       m_st = 1;
         1:       if (hlt)  m_st = 2;
         default: if (!hlt) m_st = 1;
      endcase
   endtask

   // Monitor: compares DUT outputs mid-cycle against queued expectations
   initial begin
      cyc_t e;
      ent_t x;
      forever begin
         @(negedge clk);
         if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            chk("imem_ren",   32'(imem_ren),   32'(e.ren));
            chk("imem_raddr", imem_raddr,      e.raddr);
            chk("count",      32'(count),      32'(e.cnt));
            chk("out_valid",  32'(out_valid),  32'(e.cnt != 0));
            if (out_valid && out_ready) begin
               if (out_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL pop: unexpected accept pc=%h at %0t", out_pc, $time);
               end else begin
                  x = out_q.pop_front();
                  chk("out_pc",    out_pc,    x.pc);
                  chk("out_instr", out_instr, x.instr);
               end
            end
         end
      end
   end

   initial begin
      rstn           = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;

      repeat (3)  cyc(1, 0, 0, 32'h0, 1);
      // Streaming from reset
      repeat (20) cyc(1, 0, 0, 32'h0, 0);
      // Backpressure fills the queue, then a single pop allows one more read
      repeat (10) cyc(0, 0, 0, 32'h0, 0);
      cyc(1, 0, 0, 32'h0, 0);
      cyc(0, 0, 0, 32'h0, 0);
      // Redirect with three queued entries and a read in flight
      cyc(0, 0, 1, 32'h0000_1000, 0);
      repeat (15) cyc(1, 0, 0, 32'h0, 0);
      // Halt drains the queue, then fetch resumes sequentially
      repeat (5)  cyc(1, 1, 0, 32'h0, 0);
      repeat (10) cyc(1, 0, 0, 32'h0, 0);
      // Address wrap-around past 32'hFFFF_FFFC
      cyc(1, 0, 1, 32'hFFFF_FFF4, 0);
      repeat (10) cyc(1, 0, 0, 32'h0, 0);
      // Reset pulse mid-stream with two queued entries
      cyc(0, 0, 0, 32'h0, 0);
      cyc(0, 0, 0, 32'h0, 1);
      repeat (15) cyc(1, 0, 0, 32'h0, 0);
      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
             ($urandom % 4 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC),
             ($urandom % 150) == 0);
      end
      repeat (12) cyc(1, 0, 0, 32'h0, 0);
      @(negedge clk);
      #1;
      chk("leftover_accepts", 32'(out_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
